branch_stall_ctrl: RTL and testbench

BRANCH_STALL_CTRL -- requirements
Module: branch_stall_ctrl

---
 rtl/branch_stall_ctrl.sv | 119 +++++++++++
 tb/tb_branch_stall_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_stall_ctrl.sv
// Branch hazard stall/flush controller for the decode stage.
// A branch resolved in ID needs its sources early. A load in EX costs two stall cycles:
// one in IDLE plus one in HOLD. An ALU result in EX or a load in MEM costs one stall
// cycle, after which the branch is re-evaluated.
// Optional statistics counters are enabled with the macro BRANCH_STAT_EN.
module branch_stall_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       BranchD,
    input  logic       bned,
    input  logic       equal,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic       RegWriteE,
    input  logic       MemtoRegE,
    input  logic [4:0] WriteRegE,
    input  logic       RegWriteM,
    input  logic       MemtoRegM,
    input  logic [4:0] WriteRegM,
`ifdef BRANCH_STAT_EN
    input  logic        stat_clr,
    output logic [15:0] taken_cnt,
    output logic [15:0] stall_cnt,
`endif
    output logic       StallF,
    output logic       StallD,
    output logic       FlushE,
    output logic       PCSrcD,
    output logic       FlushD,
    output logic       busy
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e state_q, state_d;

    logic match_e, match_m;
    logic haz2, haz1;

    // A load in MEM always writes, so RegWriteM adds nothing to the MEM-stage check.
    logic unused_regwritem;
    assign unused_regwritem = RegWriteM;

    // Source-register matches against the EX and MEM destinations; r0 never matches.
    always_comb begin
        match_e = (WriteRegE != 5'd0) && ((WriteRegE == RsD) || (WriteRegE == RtD));
        match_m = (WriteRegM != 5'd0) && ((WriteRegM == RsD) || (WriteRegM == RtD));
        haz2    = BranchD && RegWriteE && MemtoRegE && match_e;
        haz1    = BranchD && !haz2 &&
                  ((RegWriteE && !MemtoRegE && match_e) || (MemtoRegM && match_m));
    end

    // State register; reset forces IDLE without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and outputs; reset gates all controls low regardless of inputs.
    always_comb begin
        state_d = state_q;
        StallF  = 1'b0;
        StallD  = 1'b0;
        FlushE  = 1'b0;
        PCSrcD  = 1'b0;
        FlushD  = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                StIdle: begin
                    if (haz2 || haz1) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                        if (haz2) begin
                            state_d = StHold;
                        end
                    end else begin
                        PCSrcD = BranchD && (bned ^ equal);
                        FlushD = BranchD && (bned ^ equal);
                    end
                end
                StHold: begin
                    // Second load-use stall; inputs are ignored so HOLD is always one cycle.
                    StallF  = 1'b1;
                    StallD  = 1'b1;
                    FlushE  = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign busy = (state_q == StHold);

`ifdef BRANCH_STAT_EN
    // Saturating event counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt <= 16'd0;
            stall_cnt <= 16'd0;
        end else if (stat_clr) begin
            taken_cnt <= 16'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (PCSrcD && (taken_cnt != 16'hFFFF)) begin
                taken_cnt <= taken_cnt + 16'd1;
            end
            if (StallD && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_stall_ctrl.sv
// Scoreboard bench for branch_stall_ctrl: the driver pushes expected outputs computed by a
// stall-budget reference model; a monitor pops and compares at each falling edge.
module tb_branch_stall_ctrl;

    typedef struct packed {
        logic       rst;
        logic       br;
        logic       bne;
        logic       eq;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rwe;
        logic       mre;
        logic [4:0] wre;
        logic       rwm;
        logic       mrm;
        logic [4:0] wrm;
        logic       clr;
    } stim_t;

    // {StallF, StallD, FlushE, PCSrcD, FlushD, busy, taken_cnt, stall_cnt}
    typedef logic [37:0] exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       BranchD = 1'b0, bned = 1'b0, equal = 1'b0;
    logic [4:0] RsD = '0, RtD = '0, WriteRegE = '0, WriteRegM = '0;
    logic       RegWriteE = 1'b0, MemtoRegE = 1'b0, RegWriteM = 1'b0, MemtoRegM = 1'b0;
    logic       StallF, StallD, FlushE, PCSrcD, FlushD, busy;
    logic       stat_clr = 1'b0;
    logic [15:0] taken_cnt, stall_cnt;

    branch_stall_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .BranchD   (BranchD),
        .bned      (bned),
        .equal     (equal),
        .RsD       (RsD),
        .RtD       (RtD),
        .RegWriteE (RegWriteE),
        .MemtoRegE (MemtoRegE),
        .WriteRegE (WriteRegE),
        .RegWriteM (RegWriteM),
        .MemtoRegM (MemtoRegM),
        .WriteRegM (WriteRegM),
`ifdef BRANCH_STAT_EN
        .stat_clr  (stat_clr),
        .taken_cnt (taken_cnt),
        .stall_cnt (stall_cnt),
`endif
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushE    (FlushE),
        .PCSrcD    (PCSrcD),
        .FlushD    (FlushD),
        .busy      (busy)
    );

`ifndef BRANCH_STAT_EN
    assign taken_cnt = 16'd0;
    assign stall_cnt = 16'd0;
`endif

    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string tag_q[$];
    int    ntests = 0;
    int    nfail  = 0;

    // Reference model state: forced stall cycles still owed, and event counts.
    int owed = 0;
    int m_taken = 0;
    int m_stall = 0;

    // Apply one cycle of stimulus, push the expected response, then advance the model.
    task automatic drive(input stim_t s, input string tag);
        int   need;
        int   owed_next;
        logic stall, take;
        exp_t e;
        rst_n = s.rst; BranchD = s.br; bned = s.bne; equal = s.eq;
        RsD = s.rs; RtD = s.rt; RegWriteE = s.rwe; MemtoRegE = s.mre; WriteRegE = s.wre;
        RegWriteM = s.rwm; MemtoRegM = s.mrm; WriteRegM = s.wrm; stat_clr = s.clr;
        stall = 1'b0; take = 1'b0; owed_next = 0;
        if (!s.rst) begin
            owed = 0; m_taken = 0; m_stall = 0;
        end else if (owed > 0) begin
            stall = 1'b1;
            owed_next = owed - 1;
        end else begin
            // Stall budget for a branch depending on an in-flight producer.
            need = 0;
            if (s.br) begin
                if (s.wrm != 0 && (s.wrm == s.rs || s.wrm == s.rt) && s.mrm) need = 1;
                if (s.wre != 0 && (s.wre == s.rs || s.wre == s.rt) && s.rwe)
                    need = s.mre ? 2 : 1;
            end
            if (need > 0) begin
                stall = 1'b1;
                owed_next = need - 1;
            end else begin
                take = s.br && (s.bne != s.eq);
            end
        end
        e = {stall, stall, stall, take, take, logic'(s.rst && owed > 0), 32'd0};
`ifdef BRANCH_STAT_EN
        e[31:16] = 16'(m_taken);
        e[15:0]  = 16'(m_stall);
`endif
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (s.rst) begin
            owed = owed_next;
            if (s.clr) begin
                m_taken = 0; m_stall = 0;
            end else begin
                if (take && m_taken < 65535) m_taken++;
                if (stall && m_stall < 65535) m_stall++;
            end
        end
    endtask

    // Monitor: outputs are valid every cycle, compared mid-cycle away from the rising edge.
    initial begin
        exp_t  e, got;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                got = {StallF, StallD, FlushE, PCSrcD, FlushD, busy, taken_cnt, stall_cnt};
                ntests++;
                if (got !== e) begin
                    nfail++;
                    $display("FAIL %s: got ctrl=%b taken=%0d stall=%0d, expected ctrl=%b taken=%0d stall=%0d",
                             t, got[37:32], got[31:16], got[15:0], e[37:32], e[31:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        stim_t s;
        @(posedge clk);
        #1;
        // Reset held with a live hazard on the inputs: everything must stay low.
        s = '0; s.br = 1'b1; s.rs = 5'd4; s.rwe = 1'b1; s.mre = 1'b1; s.wre = 5'd4;
        drive(s, "reset_hazard");
        s.eq = 1'b1; s.rs = 5'd3; s.rt = 5'd3; s.rwe = 1'b0; s.mre = 1'b0; s.wre = 5'd0;
        drive(s, "reset_taken");

        // beq, equal, no producers: resolve immediately.
        s = '0; s.rst = 1'b1; s.br = 1'b1; s.eq = 1'b1; s.rs = 5'd3; s.rt = 5'd3;
        drive(s, "beq_taken");

        // bne after ALU write to r5 in EX: one stall, then resolve.
        s = '0; s.rst = 1'b1; s.br = 1'b1; s.bne = 1'b1; s.eq = 1'b0; s.rs = 5'd5;
        s.rwe = 1'b1; s.wre = 5'd5;
        drive(s, "bne_alu_stall");
        s.rwe = 1'b0; s.wre = 5'd0;
        drive(s, "bne_resolve_taken");
        s.eq = 1'b1;
        drive(s, "bne_not_taken");

        // beq after load to r7 in EX: two stalls, then load in MEM costs one more.
        s = '0; s.rst = 1'b1; s.br = 1'b1; s.rt = 5'd7; s.rwe = 1'b1; s.mre = 1'b1; s.wre = 5'd7;
        drive(s, "load_ex_stall1");
        s.rwe = 1'b0; s.mre = 1'b0; s.wre = 5'd0; s.rwm = 1'b1; s.mrm = 1'b1; s.wrm = 5'd7;
        s.br = 1'b0; // dropping BranchD in HOLD must not shorten it
        drive(s, "load_ex_hold");
        s.br = 1'b1;
        drive(s, "load_mem_stall");
        s.rwm = 1'b0; s.mrm = 1'b0; s.wrm = 5'd0;
        drive(s, "load_resolve");

        // Load to r0 never stalls.
        s = '0; s.rst = 1'b1; s.br = 1'b1; s.eq = 1'b1; s.rwe = 1'b1; s.mre = 1'b1;
        drive(s, "r0_no_stall");

        // Reset asserted mid-HOLD, between edges.
        s = '0; s.rst = 1'b1; s.br = 1'b1; s.rs = 5'd9; s.rwe = 1'b1; s.mre = 1'b1; s.wre = 5'd9;
        drive(s, "pre_reset_stall");
        s.rst = 1'b0;
        drive(s, "async_reset_in_hold");
        drive(s, "reset_held");
        s = '0; s.rst = 1'b1; s.br = 1'b1; s.bne = 1'b1; s.rs = 5'd1; s.rt = 5'd2;
        drive(s, "post_reset_taken");

        // Counter scenario: clear, 3 taken branches, one two-cycle stall, then clear+taken.
        s = '0; s.rst = 1'b1; s.clr = 1'b1;
        drive(s, "stat_clear");
        s = '0; s.rst = 1'b1; s.br = 1'b1; s.eq = 1'b1;
        for (int i = 0; i < 3; i++) drive(s, "stat_taken");
        s = '0; s.rst = 1'b1; s.br = 1'b1; s.rs = 5'd6; s.rwe = 1'b1; s.mre = 1'b1; s.wre = 5'd6;
        drive(s, "stat_stall1");
        s.rwe = 1'b0; s.mre = 1'b0; s.wre = 5'd0; s.br = 1'b0;
        drive(s, "stat_stall2");
        s = '0; s.rst = 1'b1; s.br = 1'b1; s.eq = 1'b1; s.clr = 1'b1;
        drive(s, "stat_clr_with_taken");
        s = '0; s.rst = 1'b1;
        drive(s, "stat_after_clr");

        // Random traffic over a small register set so dependencies are frequent.
        for (int i = 0; i < 400; i++) begin
            s.rst = ($urandom_range(0, 49) != 0);
            s.br  = ($urandom_range(0, 3) != 0);
            s.bne = 1'($urandom);
            s.eq  = 1'($urandom);
            s.rs  = 5'($urandom_range(0, 3));
            s.rt  = 5'($urandom_range(0, 3));
            s.rwe = 1'($urandom);
            s.mre = 1'($urandom);
            s.wre = 5'($urandom_range(0, 3));
            s.rwm = 1'($urandom);
            s.mrm = 1'($urandom);
            s.wrm = 5'($urandom_range(0, 3));
            s.clr = ($urandom_range(0, 19) == 0);
            drive(s, "random");
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            ntests++;
            nfail++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        #1;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
